seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed four-digit seven-segment scan driver that sits directly downstream of the counter/control logic in `Seven_Segment`. It takes four 4-bit digit codes and a decimal-point mask and drives one digit at a time. The driver adds anti-ghosting dead time between digits, latches the inputs once per frame so the display never tears, and blanks leading zeros on request. Both outputs are registered, active-low pins for the I/O shield display.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot (50 MHz gives 1 kHz per slot and 250 Hz per frame); legal range ≥ 2.
- `DEAD_CYCLES`, 500: cycles at the start of each slot during which all digits and segments are off; must be < `SCAN_DIV`.
- `CLK` input 1: system clock; all state updates on its rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `units`, `tens`, `hundreds`, `thousands` input 4 each: digit codes.
- `dp_mask` input 4: decimal-point enables; bit i maps to digit i (0 = units).
- `blank_lz` input 1: 1 enables leading-zero blanking.
- `SEG` output 8: active-low segments, `{dp,g,f,e,d,c,b,a}`.
- `DIGIT` output 4: active-low digit enables; bit 0 = units.
- `frame_start` output 1: one-cycle pulse when a new input snapshot is taken.

## Operation
- **Slot counter.** `cnt` runs 0..`SCAN_DIV`-1. On wrap, `slot` advances 0→1→2→3→0 (units, tens, hundreds, thousands).
- **Snapshot.** When `cnt` wraps and `slot` goes 3→0, all four digits, `dp_mask` and `blank_lz` are captured into shadow registers, and `frame_start` pulses in the same cycle the shadow registers update. Input changes between snapshots have no visible effect.
- **Per-slot phases:**
  - BLANK while `cnt` < `DEAD_CYCLES`: `SEG`=8'hFF, `DIGIT`=4'hF.
  - DRIVE for the rest of the slot: `DIGIT` has only bit `slot` low, and `SEG` is the decoded shadow digit for that slot.
- **Decode.** Codes 0–9 decode to decimal glyphs; codes 10–15 decode to hex A, b, C, d, E, F.
  - Active-low examples: 0=8'hC0, 1=8'hF9, 8=8'h80, E=8'h86.
  - The dp bit is cleared (lit) when the `dp_mask` bit for that slot is set.
- **Leading-zero blanking** (when the `blank_lz` shadow is 1):
  - thousands is blanked if it is 0;
  - hundreds is blanked if it and thousands are 0;
  - tens is blanked if it, hundreds and thousands are 0;
  - units is never blanked.
  - A blanked digit gives `SEG`=8'hFF except for dp, which still follows `dp_mask`. `DIGIT` is still driven.
- **Reset.** `cnt`=0, `slot`=0, shadows=0, `SEG`=8'hFF, `DIGIT`=4'hF, `frame_start`=0. The first snapshot is taken at the first 3→0 wrap, so frame 0 displays the zero shadows (a blank-then-"0" display with `blank_lz`=0 after reset). If `RST` asserts mid-slot, the outputs go all-off immediately.

## Timing
- Outputs are registered: `SEG`/`DIGIT` reflect the `cnt`/`slot` of the previous cycle (1-cycle latency).
- Slot length is exactly `SCAN_DIV` cycles; frame length is 4·`SCAN_DIV` cycles.
- There are never two `DIGIT` bits low at once. The BLANK phase is ≥ `DEAD_CYCLES` cycles at every slot boundary, including 3→0.
- Shadow update and the slot-0 BLANK start share one edge. The new snapshot is first visible `DEAD_CYCLES`+1 cycles after `frame_start`.
- If `DEAD_CYCLES`=0, there is no blank phase and the driver switches directly from one digit to the next.

## Structure
- Shared package `seg_pkg`:
  - active-low glyph constants (`SEG_BLANK`=8'hFF and the digit glyphs 0–F);
  - `DIGIT_OFF`=4'hF;
  - the slot enumeration (`SLOT_UNITS`..`SLOT_THOUSANDS`).
- Sub-module `seg_decode`: combinational 4-bit code → 7-bit active-low glyph, reusable by other display blocks. Leading-zero blanking and dp handling stay in `seg_scan_driver`.

## Test plan
All scenarios use `SCAN_DIV`=8 and `DEAD_CYCLES`=2.
- **Reset:** assert `RST` mid-slot → `SEG`=8'hFF and `DIGIT`=4'hF asynchronously. After release, the first DRIVE (`DIGIT`=4'hE) starts 3 cycles later and shows 8'hC0.
- **Digit scan:** digits 1,2,3,4, `blank_lz`=0, after one snapshot.
  - `DIGIT` sequence per frame is E,D,B,7, each low for 6 cycles with 2 blank cycles before it.
  - units slot shows 8'h99 (glyph 4) and thousands slot shows 8'hF9 (glyph 1).
- **Snapshot isolation:** change `units` mid-frame → `SEG` in the units slot is unchanged until after the next `frame_start`. `frame_start` pulses every 32 cycles.
- **Leading-zero blanking:** value 0,0,0,7 (thousands..units), `blank_lz`=1 → thousands, hundreds and tens slots give `SEG`=8'hFF while the units slot gives 8'hF8. Value 0000 → only units is lit, showing 8'hC0.
- **Decimal point and hex:** `dp_mask`=4'b0100, hundreds=4'hE → hundreds slot `SEG`=8'h06, all other slots have bit 7 high.
- **Overlap check:** across 1000 frames with random inputs, an assertion confirms `DIGIT` never has more than one bit low, and `SEG` is 8'hFF in every blank cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display blocks.
// Glyphs are active-low {dp,g,f,e,d,c,b,a} with the dp bit off.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] DIGIT_OFF = 4'hF;

    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

    typedef enum logic [1:0] {
        SLOT_UNITS     = 2'd0,
        SLOT_TENS      = 2'd1,
        SLOT_HUNDREDS  = 2'd2,
        SLOT_THOUSANDS = 2'd3
    } slot_e;

    typedef struct packed {
        logic [3:0] thousands;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] units;
        logic [3:0] dp_mask;
        logic       blank_lz;
    } frame_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational hex code to active-low seven-segment glyph {g,f,e,d,c,b,a}.
// Blanking and decimal-point handling belong to the caller.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] glyph
);

    always_comb begin
        case (code)
            4'h0:    glyph = GLYPH_0[6:0];
            4'h1:    glyph = GLYPH_1[6:0];
            4'h2:    glyph = GLYPH_2[6:0];
            4'h3:    glyph = GLYPH_3[6:0];
            4'h4:    glyph = GLYPH_4[6:0];
            4'h5:    glyph = GLYPH_5[6:0];
            4'h6:    glyph = GLYPH_6[6:0];
            4'h7:    glyph = GLYPH_7[6:0];
            4'h8:    glyph = GLYPH_8[6:0];
            4'h9:    glyph = GLYPH_9[6:0];
            4'hA:    glyph = GLYPH_A[6:0];
            4'hB:    glyph = GLYPH_B[6:0];
            4'hC:    glyph = GLYPH_C[6:0];
            4'hD:    glyph = GLYPH_D[6:0];
            4'hE:    glyph = GLYPH_E[6:0];
            default: glyph = GLYPH_F[6:0];
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with dead time between digits,
// once-per-frame input snapshot and optional leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    input  logic [3:0] dp_mask,
    input  logic       blank_lz,
    output logic [7:0] SEG,
    output logic [3:0] DIGIT,
    output logic       frame_start
);

    localparam int              CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_e            slot_q, slot_d;
    frame_t           shadow_q, shadow_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       digit_q, digit_d;
    logic             frame_start_q, frame_start_d;

    logic             cnt_wrap;
    logic [3:0]       code;
    logic [6:0]       glyph;
    logic             lz_blank;

    seg_decode u_decode (
        .code  (code),
        .glyph (glyph)
    );

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_wrap      = (cnt_q == CNT_MAX);
        cnt_d         = cnt_wrap ? '0 : cnt_q + 1'b1;
        slot_d        = cnt_wrap ? slot_e'(slot_q + 2'd1) : slot_q;
        frame_start_d = cnt_wrap && (slot_q == SLOT_THOUSANDS);
        shadow_d      = shadow_q;
        if (frame_start_d) begin
            shadow_d = '{thousands: thousands, hundreds: hundreds, tens: tens,
                         units: units, dp_mask: dp_mask, blank_lz: blank_lz};
        end
    end

    // A digit is blanked when it and every more significant digit are zero.
    always_comb begin
        code     = shadow_q.units;
        lz_blank = 1'b0;
        case (slot_q)
            SLOT_UNITS: begin
                code = shadow_q.units;
            end
            SLOT_TENS: begin
                code     = shadow_q.tens;
                lz_blank = (shadow_q.tens == 4'h0) && (shadow_q.hundreds == 4'h0)
                           && (shadow_q.thousands == 4'h0);
            end
            SLOT_HUNDREDS: begin
                code     = shadow_q.hundreds;
                lz_blank = (shadow_q.hundreds == 4'h0) && (shadow_q.thousands == 4'h0);
            end
            default: begin
                code     = shadow_q.thousands;
                lz_blank = (shadow_q.thousands == 4'h0);
            end
        endcase

        seg_d   = SEG_BLANK;
        digit_d = DIGIT_OFF;
        if (cnt_q >= DEAD_END) begin
            digit_d = ~(4'b0001 << slot_q);
            seg_d   = {~shadow_q.dp_mask[slot_q],
                       (lz_blank && shadow_q.blank_lz) ? 7'h7F : glyph};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    // NOTE: the shadow registers are reset too, so frame 0 shows a defined all-zero value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q         <= '0;
            slot_q        <= SLOT_UNITS;
            shadow_q      <= '0;
            seg_q         <= SEG_BLANK;
            digit_q       <= DIGIT_OFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            seg_q         <= seg_d;
            digit_q       <= digit_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign SEG         = seg_q;
    assign DIGIT       = digit_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: cycle-index reference model,
// directed scenarios with literal expectations, then randomized frames.
module tb_seg_scan_driver;

    localparam int SCAN_DIV    = 8;
    localparam int DEAD_CYCLES = 2;
    localparam int FRAME       = 4 * SCAN_DIV;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] units = 4'h0, tens = 4'h0, hundreds = 4'h0, thousands = 4'h0;
    logic [3:0] dp_mask = 4'h0;
    logic       blank_lz = 1'b0;
    logic [7:0] SEG;
    logic [3:0] DIGIT;
    logic       frame_start;

    int compared   = 0;
    int mismatched = 0;
    logic cmp_en   = 1'b0;

    always #5 CLK = ~CLK;

    seg_scan_driver #(
        .SCAN_DIV    (SCAN_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .units       (units),
        .tens        (tens),
        .hundreds    (hundreds),
        .thousands   (thousands),
        .dp_mask     (dp_mask),
        .blank_lz    (blank_lz),
        .SEG         (SEG),
        .DIGIT       (DIGIT),
        .frame_start (frame_start)
    );

    // Standard active-low hex glyphs, dp off.
    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts clock edges since reset release. The output
    // after edge k shows the position reached after k-1 edges; snapshots are
    // taken at every edge that is a multiple of the frame length.
    int          k = 0;
    int          m_c, m_s;
    logic [15:0] m_digits = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic        m_lz = 1'b0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [3:0]  exp_digit = 4'hF;
    logic        exp_fs = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            k = 0; m_digits = 16'h0; m_dp = 4'h0; m_lz = 1'b0;
            exp_seg = 8'hFF; exp_digit = 4'hF; exp_fs = 1'b0;
        end else begin
            m_c = k % SCAN_DIV;
            m_s = (k / SCAN_DIV) % 4;
            k   = k + 1;
            if (m_c < DEAD_CYCLES) begin
                exp_seg   = 8'hFF;
                exp_digit = 4'hF;
            end else begin
                exp_digit       = 4'hF;
                exp_digit[m_s]  = 1'b0;
                if (m_lz && m_s != 0 && (m_digits >> (4 * m_s)) == 16'h0)
                    exp_seg = 8'hFF;
                else
                    exp_seg = glyph_tab[m_digits[4*m_s +: 4]];
                exp_seg[7] = ~m_dp[m_s];
            end
            exp_fs = (k % FRAME == 0);
            if (exp_fs) begin
                m_digits = {thousands, hundreds, tens, units};
                m_dp     = dp_mask;
                m_lz     = blank_lz;
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("seg_model", {24'h0, SEG}, {24'h0, exp_seg});
            check("digit_model", {28'h0, DIGIT}, {28'h0, exp_digit});
            check("frame_start_model", {31'h0, frame_start}, {31'h0, exp_fs});
        end
    end

    always @(negedge CLK) begin
        assert ($countones(~DIGIT) <= 1) else $error("more than one digit enabled: %h", DIGIT);
        if (DIGIT == 4'hF) begin
            assert (SEG == 8'hFF) else $error("segments lit while no digit enabled: %h", SEG);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int n;
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        cmp_en = 1'b1;
        check("reset_seg", {24'h0, SEG}, 32'hFF);
        check("reset_digit", {28'h0, DIGIT}, 32'hF);
        check("reset_frame_start", {31'h0, frame_start}, 32'h0);

        // Digits thousands..units = 1,2,3,4, captured at the first wrap
        thousands = 4'd1; hundreds = 4'd2; tens = 4'd3; units = 4'd4;
        @(negedge CLK);
        RST = 1'b0;
        step(2);   // k=2
        check("first_blank_digit", {28'h0, DIGIT}, 32'hF);
        step(1);   // k=3
        check("first_drive_digit", {28'h0, DIGIT}, 32'hE);
        check("first_drive_seg", {24'h0, SEG}, 32'hC0);
        step(29);  // k=32
        check("frame_start_pulse", {31'h0, frame_start}, 32'h1);
        step(1);   // k=33
        check("frame_start_single", {31'h0, frame_start}, 32'h0);
        step(2);   // k=35
        check("units_glyph4", {24'h0, SEG}, 32'h99);
        units = 4'd8;
        step(3);   // k=38
        check("units_isolated", {24'h0, SEG}, 32'h99);
        step(21);  // k=59
        check("thousands_digit", {28'h0, DIGIT}, 32'h7);
        check("thousands_glyph1", {24'h0, SEG}, 32'hF9);
        step(5);   // k=64
        check("frame_start_period", {31'h0, frame_start}, 32'h1);
        step(3);   // k=67
        check("units_after_snapshot", {24'h0, SEG}, 32'h80);

        // Leading-zero blanking: 0,0,0,7
        thousands = 4'd0; hundreds = 4'd0; tens = 4'd0; units = 4'd7; blank_lz = 1'b1;
        step(33);  // k=100
        check("lz_units", {24'h0, SEG}, 32'hF8);
        step(8);   // k=108
        check("lz_tens_digit", {28'h0, DIGIT}, 32'hD);
        check("lz_tens", {24'h0, SEG}, 32'hFF);
        step(8);   // k=116
        check("lz_hundreds", {24'h0, SEG}, 32'hFF);
        step(8);   // k=124
        check("lz_thousands", {24'h0, SEG}, 32'hFF);
        units = 4'd0;
        step(8);   // k=132
        check("lz_zero_units", {24'h0, SEG}, 32'hC0);
        step(8);   // k=140
        check("lz_zero_tens", {24'h0, SEG}, 32'hFF);

        // Decimal point on hundreds, hex E
        dp_mask = 4'b0100; hundreds = 4'hE; blank_lz = 1'b0;
        step(24);  // k=164
        check("dp_units_off", {24'h0, SEG}, 32'hC0);
        step(16);  // k=180
        check("dp_hundreds_digit", {28'h0, DIGIT}, 32'hB);
        check("dp_hundreds_E", {24'h0, SEG}, 32'h06);
        step(8);   // k=188
        check("dp_thousands_off", {24'h0, SEG}, 32'hC0);

        // Randomized frames, inputs changed at an arbitrary point in each frame
        for (int f = 0; f < 1000; f++) begin
            r = $urandom_range(1, FRAME - 1);
            repeat (r) @(negedge CLK);
            units     = 4'($urandom);
            tens      = 4'($urandom);
            hundreds  = 4'($urandom);
            thousands = 4'($urandom);
            dp_mask   = 4'($urandom);
            blank_lz  = 1'($urandom);
            repeat (FRAME - r) @(negedge CLK);
        end

        // Asynchronous reset in the middle of a drive phase
        n = 0;
        while (DIGIT == 4'hF && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("drive_before_reset", {31'h0, (DIGIT != 4'hF)}, 32'h1);
        #1;
        RST = 1'b1;
        #1;
        check("async_reset_seg", {24'h0, SEG}, 32'hFF);
        check("async_reset_digit", {28'h0, DIGIT}, 32'hF);
        @(negedge CLK);
        RST = 1'b0;
        step(2);
        check("rerelease_blank", {28'h0, DIGIT}, 32'hF);
        step(1);
        check("rerelease_digit", {28'h0, DIGIT}, 32'hE);
        check("rerelease_seg", {24'h0, SEG}, 32'hC0);
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
